// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. CLK is the bit clock (one period per bit).
// Each accepted word goes out as one frame, LSB first:
// start (0), DATA_WIDTH data bits, optional parity bit, stop (1).
//
// Ports:
//   CLK        - TX bit clock, rising edge
//   RST        - asynchronous reset, active low
//   P_DATA     - word to send, captured on acceptance
//   DATA_VALID - send request, honoured only while idle
//   PAR_EN     - 1 = append a parity bit, captured on acceptance
//   PAR_TYP    - 0 = even parity, 1 = odd parity, captured on acceptance
//   TX_OUT     - registered serial line, idles high
//   BUSY       - registered, high for every bit time from start to stop
//
// state  | meaning
// IDLE   | line high, waiting for DATA_VALID
// START  | start bit (0) on the line
// DATA   | data bit cnt on the line
// PARITY | parity bit on the line
// STOP   | stop bit (1) on the line
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic [DATA_WIDTH-1:0] data;
  logic                  par_en;
  logic                  par_bit;

  assign cnt_nxt = cnt + CW'(1);

  // TX_OUT/BUSY are loaded with the value for the state being entered, so
  // the line changes on the same edge as the state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      cnt     <= '0;
      data    <= '0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      TX_OUT  <= 1'b1;
      BUSY    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
          if (DATA_VALID) begin
            data    <= P_DATA;
            par_en  <= PAR_EN;
            // odd parity is the inverted XOR of the word
            par_bit <= (^P_DATA) ^ PAR_TYP;
            state   <= START;
            TX_OUT  <= 1'b0;
            BUSY    <= 1'b1;
          end
        end
        START: begin
          cnt    <= '0;
          TX_OUT <= data[0];
          state  <= DATA;
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (par_en) begin
              TX_OUT <= par_bit;
              state  <= PARITY;
            end else begin
              TX_OUT <= 1'b1;
              state  <= STOP;
            end
          end else begin
            cnt    <= cnt_nxt;
            TX_OUT <= data[cnt_nxt];
          end
        end
        PARITY: begin
          TX_OUT <= 1'b1;
          state  <= STOP;
        end
        STOP: begin
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       BUSY;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected frame bits are written left-to-right in time order.
  task automatic check_bits(input string tag, input logic [15:0] seq, input int len,
                            input int inj_at);
    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      chk($sformatf("%s tx[%0d]", tag, i), 32'(TX_OUT), 32'(seq[len-1-i]));
      chk($sformatf("%s busy[%0d]", tag, i), 32'(BUSY), 32'd1);
      if (i == inj_at) begin
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b1;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1;
        DATA_VALID = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk($sformatf("%s tx[%0d]", tag, i), 32'(TX_OUT), 32'd1);
      chk($sformatf("%s busy[%0d]", tag, i), 32'(BUSY), 32'd0);
    end
  endtask

  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
    @(posedge CLK);
    #1;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    DATA_VALID = 1'b1;
    @(posedge CLK);
    #1;
    DATA_VALID = 1'b0;
  endtask

  initial begin
    // reset held for 3 cycles, then 20 idle cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst tx", 32'(TX_OUT), 32'd1);
      chk("rst busy", 32'(BUSY), 32'd0);
    end
    RST = 1'b1;
    check_idle("idle", 20);

    // 0xA5 even parity
    start_frame(8'hA5, 1'b1, 1'b0);
    check_bits("a5_even", 16'(11'b01010010101), 11, -1);
    check_idle("a5_even end", 2);

    // 0xA5 odd parity
    start_frame(8'hA5, 1'b1, 1'b1);
    check_bits("a5_odd", 16'(11'b01010010111), 11, -1);
    check_idle("a5_odd end", 2);

    // 0x01 no parity
    start_frame(8'h01, 1'b0, 1'b0);
    check_bits("01_nopar", 16'(10'b0100000001), 10, -1);
    check_idle("01_nopar end", 2);

    // 0x3C with a new request and new data injected at data bit 3
    start_frame(8'h3C, 1'b0, 1'b0);
    check_bits("3c_inject", 16'(10'b0001111001), 10, 4);
    check_idle("3c no second frame", 4);

    // back-to-back with DATA_VALID held high
    @(posedge CLK);
    #1;
    P_DATA     = 8'h55;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    DATA_VALID = 1'b1;
    @(posedge CLK);
    #1;
    P_DATA = 8'hAA;
    check_bits("b2b_55", 16'(10'b0101010101), 10, -1);
    check_idle("b2b gap", 1);
    check_bits("b2b_aa", 16'(10'b0010101011), 10, -1);
    DATA_VALID = 1'b0;
    check_idle("b2b end", 3);

    // async reset during data bit 4 of 0x00
    start_frame(8'h00, 1'b0, 1'b0);
    check_bits("00_pre_rst", 16'(5'b00000), 5, -1);
    @(negedge CLK);
    chk("00 bit4 busy", 32'(BUSY), 32'd1);
    RST = 1'b0;
    #1;
    chk("async rst tx", 32'(TX_OUT), 32'd1);
    chk("async rst busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    check_idle("post rst", 3);
    start_frame(8'h81, 1'b0, 1'b0);
    check_bits("81_after_rst", 16'(10'b0100000011), 10, -1);
    check_idle("81 end", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
